multicycle_ctrl: RTL and testbench

Multi-cycle main control FSM for the RV32I processor datapath. It sequences one shared memory port, the ALU/ALU-control pair and the branch-target adder through FETCH/DECODE/EXEC/MEM/WB, driving `aluop`/`alusrc` into the ALU-control + ALU path and selecting the next PC from PC+4, `pc_branch` or `alu_output`. It keeps a retired-instruction counter and traps on unsupported opcodes.

---
 rtl/ctrl_pkg.sv | 60 ++++++
 rtl/ctrl_decode.sv | 33 +++
 rtl/multicycle_ctrl.sv | 146 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM
// and the ALU-control block it feeds.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CL_R,
        CL_I,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JAL,
        CL_JALR,
        CL_ILL
    } cls_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [1:0] PCSRC_PC4 = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_ALU = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    function automatic logic [1:0] aluop_of(input cls_t c);
        unique case (c)
            CL_R:      return ALUOP_R;
            CL_I:      return ALUOP_I;
            CL_BRANCH: return ALUOP_SUB;
            default:   return ALUOP_ADD;
        endcase
    endfunction

    function automatic logic alusrc_of(input cls_t c);
        return (c == CL_I) || (c == CL_LOAD) ||
               (c == CL_STORE) || (c == CL_JALR);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Opcode/funct3 classifier: maps the instruction to a
// control class and flags anything unsupported.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_f3,
    output cls_t       o_cls,
    output logic       o_illegal
);

    logic w_br_ok;

    // only BEQ and BNE are implemented
    assign w_br_ok = (i_f3 == 3'b000) || (i_f3 == 3'b001);

    always_comb begin
        o_cls = CL_ILL;
        unique case (1'b1)
            (i_opcode == OP_R):      o_cls = CL_R;
            (i_opcode == OP_I):      o_cls = CL_I;
            (i_opcode == OP_LOAD):   o_cls = CL_LOAD;
            (i_opcode == OP_STORE):  o_cls = CL_STORE;
            (i_opcode == OP_BRANCH): o_cls = w_br_ok ? CL_BRANCH : CL_ILL;
            (i_opcode == OP_JAL):    o_cls = CL_JAL;
            (i_opcode == OP_JALR):   o_cls = CL_JALR;
            default:                 o_cls = CL_ILL;
        endcase
    end

    assign o_illegal = (o_cls == CL_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM: sequences FETCH/DECODE/EXEC/MEM/WB,
// counts retired instructions and traps on unsupported opcodes.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           f3,
    input  logic                 zero_flag,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 iord,
    output logic                 ir_write,
    output logic [1:0]           aluop,
    output logic                 alusrc,
    output logic                 reg_write,
    output logic [1:0]           wb_sel,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    state_t                r_state;
    cls_t                  r_cls;
    logic [INSTRET_W-1:0]  r_instret;

    state_t     w_next;
    cls_t       w_cls;
    logic       w_dec_ill;
    logic       w_taken;
    logic       w_mem_req, w_mem_we, w_iord, w_ir_write;
    logic [1:0] w_aluop, w_wb_sel, w_pc_src;
    logic       w_alusrc, w_reg_write, w_pc_write, w_trap;

    ctrl_decode u_dec (
        .i_opcode  (opcode),
        .i_f3      (f3),
        .o_cls     (w_cls),
        .o_illegal (w_dec_ill)
    );

    // f3[0] separates BNE from BEQ once the class is known legal
    assign w_taken = f3[0] ? ~zero_flag : zero_flag;

    always_comb begin
        w_next      = r_state;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_iord      = 1'b0;
        w_ir_write  = 1'b0;
        w_aluop     = ALUOP_ADD;
        w_alusrc    = 1'b0;
        w_reg_write = 1'b0;
        w_wb_sel    = WB_ALU;
        w_pc_write  = 1'b0;
        w_pc_src    = PCSRC_PC4;
        w_trap      = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: w_next = w_dec_ill ? S_TRAP : S_EXEC;
            S_EXEC: begin
                w_aluop  = aluop_of(r_cls);
                w_alusrc = alusrc_of(r_cls);
                unique case (r_cls)
                    CL_R, CL_I:         w_next = S_WB;
                    CL_LOAD, CL_STORE:  w_next = S_MEM;
                    CL_BRANCH: begin
                        w_pc_write = 1'b1;
                        w_pc_src   = w_taken ? PCSRC_BR : PCSRC_PC4;
                        w_next     = S_FETCH;
                    end
                    CL_JAL, CL_JALR: begin
                        w_reg_write = 1'b1;
                        w_wb_sel    = WB_PC4;
                        w_pc_write  = 1'b1;
                        w_pc_src    = (r_cls == CL_JAL) ? PCSRC_BR : PCSRC_ALU;
                        w_next      = S_FETCH;
                    end
                    default:            w_next = S_TRAP;
                endcase
            end
            S_MEM: begin
                w_aluop   = aluop_of(r_cls);
                w_alusrc  = alusrc_of(r_cls);
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                w_mem_we  = (r_cls == CL_STORE);
                if (mem_ready) begin
                    w_reg_write = (r_cls == CL_LOAD);
                    w_wb_sel    = (r_cls == CL_LOAD) ? WB_MEM : WB_ALU;
                    w_pc_write  = 1'b1;
                    w_next      = S_FETCH;
                end
            end
            S_WB: begin
                w_aluop     = aluop_of(r_cls);
                w_alusrc    = alusrc_of(r_cls);
                w_reg_write = 1'b1;
                w_pc_write  = 1'b1;
                w_next      = S_FETCH;
            end
            S_TRAP:  w_trap = 1'b1;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_cls     <= CL_R;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_cls <= w_cls;
            if (w_pc_write)
                r_instret <= r_instret + INSTRET_W'(1);
        end
    end

    // reset low silences every control line immediately
    assign mem_req   = rst_n & w_mem_req;
    assign mem_we    = rst_n & w_mem_we;
    assign iord      = rst_n & w_iord;
    assign ir_write  = rst_n & w_ir_write;
    assign aluop     = {2{rst_n}} & w_aluop;
    assign alusrc    = rst_n & w_alusrc;
    assign reg_write = rst_n & w_reg_write;
    assign wb_sel    = {2{rst_n}} & w_wb_sel;
    assign pc_write  = rst_n & w_pc_write;
    assign pc_src    = {2{rst_n}} & w_pc_src;
    assign illegal   = rst_n & w_trap;
    assign instret   = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed per-cycle
// expectations queued by stimulus, checked by a monitor.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    typedef struct packed {
        logic        mreq;
        logic        mwe;
        logic        iord;
        logic        irw;
        logic [1:0]  aop;
        logic        asrc;
        logic        rw;
        logic [1:0]  wbs;
        logic        pcw;
        logic [1:0]  pcs;
        logic        ill;
        logic [31:0] ir;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic        zero_flag, mem_ready;
    logic        mem_req, mem_we, iord, ir_write, alusrc;
    logic        reg_write, pc_write, illegal;
    logic [1:0]  aluop, wb_sel, pc_src;
    logic [31:0] instret;

    logic        w2_mreq, w2_mwe, w2_iord, w2_irw, w2_asrc;
    logic        w2_rw, w2_pcw, w2_ill;
    logic [1:0]  w2_aop, w2_wbs, w2_pcs;
    logic [2:0]  w2_instret;

    exp_t  q[$];
    string tq[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic [31:0] exp_ir = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .f3(f3),
        .zero_flag(zero_flag), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .aluop(aluop), .alusrc(alusrc),
        .reg_write(reg_write), .wb_sel(wb_sel), .pc_write(pc_write),
        .pc_src(pc_src), .illegal(illegal), .instret(instret)
    );

    // narrow counter instance runs JALs to exercise wraparound
    multicycle_ctrl #(.INSTRET_W(3)) dut2 (
        .clk(clk), .rst_n(rst2_n), .opcode(OP_JAL), .f3(3'b000),
        .zero_flag(1'b0), .mem_ready(1'b1),
        .mem_req(w2_mreq), .mem_we(w2_mwe), .iord(w2_iord),
        .ir_write(w2_irw), .aluop(w2_aop), .alusrc(w2_asrc),
        .reg_write(w2_rw), .wb_sel(w2_wbs), .pc_write(w2_pcw),
        .pc_src(w2_pcs), .illegal(w2_ill), .instret(w2_instret)
    );

    function automatic exp_t mk(
        input bit mreq, input bit mwe, input bit io, input bit irw,
        input logic [1:0] aop, input bit asrc, input bit rw,
        input logic [1:0] wbs, input bit pcw, input logic [1:0] pcs,
        input bit ill);
        exp_t e;
        e = '{mreq, mwe, io, irw, aop, asrc, rw, wbs, pcw, pcs, ill, 32'd0};
        return e;
    endfunction

    localparam exp_t Z = '0;

    always @(negedge clk) begin
        exp_t  e;
        exp_t  a;
        string t;
        if (q.size() > 0) begin
            e = q.pop_front();
            t = tq.pop_front();
            a = '{mem_req, mem_we, iord, ir_write, aluop, alusrc,
                  reg_write, wb_sel, pc_write, pc_src, illegal, instret};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", t, a, e);
            end
        end
    end

    task automatic step(input logic rdy, input exp_t e, input string t);
        mem_ready = rdy;
        e.ir = exp_ir;
        q.push_back(e);
        tq.push_back(t);
        @(posedge clk);
        #1;
        if (e.pcw) exp_ir++;
    endtask

    task automatic fetch(input int waits, input string t);
        for (int i = 0; i < waits; i++)
            step(1'b0, mk(1,0,0,0,2'b00,0,0,2'b00,0,2'b00,0), t);
        step(1'b1, mk(1,0,0,1,2'b00,0,0,2'b00,0,2'b00,0), t);
    endtask

    task automatic dec(input string t);
        step(1'b1, Z, t);
    endtask

    task automatic run_r(input string t);
        opcode = OP_R;
        fetch(0, t);
        dec(t);
        step(1'b1, mk(0,0,0,0,2'b10,0,0,2'b00,0,2'b00,0), t);
        step(1'b1, mk(0,0,0,0,2'b10,0,1,2'b00,1,2'b00,0), t);
    endtask

    task automatic check2(input logic [2:0] want, input string t);
        n_cmp++;
        if (w2_instret !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", t, w2_instret, want);
        end
    endtask

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        opcode = OP_R; f3 = 3'b000;
        zero_flag = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, Z, "reset");
        rst_n = 1'b1;

        run_r("r_type");

        opcode = OP_I;
        fetch(3, "i_fetch_wait");
        dec("i_dec");
        step(1'b1, mk(0,0,0,0,2'b11,1,0,2'b00,0,2'b00,0), "i_ex");
        step(1'b1, mk(0,0,0,0,2'b11,1,1,2'b00,1,2'b00,0), "i_wb");

        opcode = OP_BRANCH; f3 = 3'b000; zero_flag = 1'b1;
        fetch(0, "beq"); dec("beq");
        step(1'b1, mk(0,0,0,0,2'b01,0,0,2'b00,1,2'b01,0), "beq_taken");
        f3 = 3'b001;
        fetch(0, "bne"); dec("bne");
        step(1'b1, mk(0,0,0,0,2'b01,0,0,2'b00,1,2'b00,0), "bne_not");
        zero_flag = 1'b0;
        fetch(0, "bne"); dec("bne");
        step(1'b1, mk(0,0,0,0,2'b01,0,0,2'b00,1,2'b01,0), "bne_taken");

        opcode = OP_JAL; f3 = 3'b000;
        fetch(0, "jal"); dec("jal");
        step(1'b1, mk(0,0,0,0,2'b00,0,1,2'b10,1,2'b01,0), "jal_ex");
        opcode = OP_JALR;
        fetch(0, "jalr"); dec("jalr");
        step(1'b1, mk(0,0,0,0,2'b00,1,1,2'b10,1,2'b10,0), "jalr_ex");

        opcode = OP_LOAD; f3 = 3'b010;
        fetch(0, "load"); dec("load");
        step(1'b1, mk(0,0,0,0,2'b00,1,0,2'b00,0,2'b00,0), "load_ex");
        step(1'b0, mk(1,0,1,0,2'b00,1,0,2'b00,0,2'b00,0), "load_wait");
        step(1'b0, mk(1,0,1,0,2'b00,1,0,2'b00,0,2'b00,0), "load_wait");
        step(1'b1, mk(1,0,1,0,2'b00,1,1,2'b01,1,2'b00,0), "load_done");

        opcode = OP_STORE;
        fetch(0, "store"); dec("store");
        step(1'b1, mk(0,0,0,0,2'b00,1,0,2'b00,0,2'b00,0), "store_ex");
        step(1'b1, mk(1,1,1,0,2'b00,1,0,2'b00,1,2'b00,0), "store_mem");

        fetch(0, "st_rst"); dec("st_rst");
        step(1'b1, mk(0,0,0,0,2'b00,1,0,2'b00,0,2'b00,0), "st_rst_ex");
        step(1'b0, mk(1,1,1,0,2'b00,1,0,2'b00,0,2'b00,0), "st_rst_wait");
        rst_n = 1'b0;
        exp_ir = 0;
        step(1'b0, Z, "mid_reset");
        rst_n = 1'b1;
        fetch(0, "post_rst_fetch"); dec("post_rst");
        step(1'b1, mk(0,0,0,0,2'b00,1,0,2'b00,0,2'b00,0), "post_rst_ex");
        step(1'b1, mk(1,1,1,0,2'b00,1,0,2'b00,1,2'b00,0), "post_rst_mem");

        opcode = OP_BRANCH; f3 = 3'b100;
        fetch(0, "bad_f3"); dec("bad_f3");
        for (int i = 0; i < 3; i++)
            step(1'b1, mk(0,0,0,0,2'b00,0,0,2'b00,0,2'b00,1), "trap_f3");

        rst_n = 1'b0;
        exp_ir = 0;
        step(1'b1, Z, "trap_reset");
        rst_n = 1'b1;
        f3 = 3'b000;
        run_r("r_pre_trap");
        opcode = 7'b1110011;
        fetch(0, "system"); dec("system");
        for (int i = 0; i < 3; i++)
            step(1'b1, mk(0,0,0,0,2'b00,0,0,2'b00,0,2'b00,1), "trap_sys");

        rst2_n = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        check2(3'd7, "wrap_pre");
        repeat (3) @(posedge clk);
        #1;
        check2(3'd0, "wrap_zero");

        @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d left want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
